// File: rtl/soc_sram_arb2.sv
// soc_sram_arb2: two-requester arbiter in front of a single-port synchronous SRAM.
// Grants are combinational. Simultaneous requests are resolved round-robin.
// Read data comes back one cycle after the grant and is tagged to its owner.
// Optional grant locking is compiled in with the macro SOC_SRAM_ARB_LOCK_EN.
module soc_sram_arb2 #(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned WORD_AW = 12,
  localparam int unsigned SW      = XLEN / 8
) (
  input  logic               ahb4_clk_i,
  input  logic               ahb4_rst_i,

  input  logic               req0_ce_i,
  input  logic               req0_we_i,
  input  logic [WORD_AW-1:0] req0_addr_i,
  input  logic [XLEN-1:0]    req0_din_i,
  input  logic [SW-1:0]      req0_sel_i,
  input  logic               req0_lock_i,
  output logic               req0_gnt_o,
  output logic               req0_rvalid_o,
  output logic [XLEN-1:0]    req0_dout_o,

  input  logic               req1_ce_i,
  input  logic               req1_we_i,
  input  logic [WORD_AW-1:0] req1_addr_i,
  input  logic [XLEN-1:0]    req1_din_i,
  input  logic [SW-1:0]      req1_sel_i,
  input  logic               req1_lock_i,
  output logic               req1_gnt_o,
  output logic               req1_rvalid_o,
  output logic [XLEN-1:0]    req1_dout_o,

  output logic               sram_ce,
  output logic               sram_we,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [XLEN-1:0]    sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [XLEN-1:0]    sram_dout
);

  // last_grant_q holds the index of the most recently granted requester
  logic       last_grant_q, last_grant_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  logic [1:0] req_c;
  logic [1:0] elig_c;
  logic [1:0] gnt_c;

  assign req_c = {req1_ce_i, req0_ce_i};

`ifdef SOC_SRAM_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_owner_q, lock_owner_d;
  logic lock_hold_c;

  // Lock stays in force only while the owner keeps its lock input high
  always_comb begin
    lock_hold_c = lock_q & (lock_owner_q ? req1_lock_i : req0_lock_i);
  end

  // A held lock masks the other requester out of arbitration
  always_comb begin
    elig_c = req_c;
    if (lock_hold_c) begin
      elig_c = lock_owner_q ? {req1_ce_i, 1'b0} : {1'b0, req0_ce_i};
    end
  end

  // Lock is (re)taken by whoever is granted with lock asserted
  always_comb begin
    lock_d       = lock_hold_c;
    lock_owner_d = lock_owner_q;
    if (gnt_c[0]) begin
      lock_d       = req0_lock_i;
      lock_owner_d = 1'b0;
    end else if (gnt_c[1]) begin
      lock_d       = req1_lock_i;
      lock_owner_d = 1'b1;
    end
  end

  // Lock state register
  always_ff @(posedge ahb4_clk_i) begin
    if (ahb4_rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock_c;

  // Lock inputs have no effect in this build
  assign unused_lock_c = req0_lock_i ^ req1_lock_i;

  // Every requester is always eligible
  always_comb begin
    elig_c = req_c;
  end
`endif

  // Round-robin pick: on conflict the requester not granted last wins
  always_comb begin
    gnt_c = 2'b00;
    if (!ahb4_rst_i) begin
      if (elig_c == 2'b11) begin
        gnt_c = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        gnt_c = elig_c;
      end
    end
  end

  assign req0_gnt_o = gnt_c[0];
  assign req1_gnt_o = gnt_c[1];

  // Steer the granted requester onto the SRAM port, zero when idle
  always_comb begin
    sram_ce    = gnt_c[0] | gnt_c[1];
    sram_we    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = '0;
    if (gnt_c[0]) begin
      sram_we    = req0_we_i;
      sram_waddr = req0_addr_i;
      sram_din   = req0_din_i;
      sram_sel   = req0_sel_i;
    end else if (gnt_c[1]) begin
      sram_we    = req1_we_i;
      sram_waddr = req1_addr_i;
      sram_din   = req1_din_i;
      sram_sel   = req1_sel_i;
    end
  end

  // Next-state for round-robin pointer and read tracking
  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    if (gnt_c[0]) begin
      last_grant_d = 1'b0;
    end else if (gnt_c[1]) begin
      last_grant_d = 1'b1;
    end
    if (sram_ce && !sram_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = gnt_c[1];
    end
  end

  // Arbiter state register; reset makes requester 0 win the first conflict
  always_ff @(posedge ahb4_clk_i) begin
    if (ahb4_rst_i) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read-valid goes to the owner of the previous cycle's read; suppressed in reset
  always_comb begin
    req0_rvalid_o = rd_pend_q & ~rd_owner_q & ~ahb4_rst_i;
    req1_rvalid_o = rd_pend_q &  rd_owner_q & ~ahb4_rst_i;
  end

  assign req0_dout_o = sram_dout;
  assign req1_dout_o = sram_dout;

endmodule

// File: tb/tb_soc_sram_arb2.sv
// Bench for soc_sram_arb2: table vectors, directed corner sequences and
// randomized traffic checked against a behavioural arbitration/memory model.
// Build with +define+SOC_SRAM_ARB_LOCK_EN to exercise the lock feature.
`timescale 1ns/1ps
module tb_soc_sram_arb2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned WORD_AW = 12;
  localparam int unsigned SW      = XLEN / 8;
  localparam int unsigned DEPTH   = 1 << WORD_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               ce   [2];
  logic               we   [2];
  logic [WORD_AW-1:0] addr [2];
  logic [XLEN-1:0]    din  [2];
  logic [SW-1:0]      sel  [2];
  logic               lock [2];

  logic               gnt0, gnt1, rv0, rv1;
  logic [XLEN-1:0]    dout0, dout1;
  logic               sram_ce, sram_we;
  logic [WORD_AW-1:0] sram_waddr;
  logic [XLEN-1:0]    sram_din;
  logic [SW-1:0]      sram_sel;
  logic [XLEN-1:0]    sram_dout = '0;

  soc_sram_arb2 #(.XLEN(XLEN), .WORD_AW(WORD_AW)) dut (
    .ahb4_clk_i   (clk),
    .ahb4_rst_i   (rst),
    .req0_ce_i    (ce[0]),
    .req0_we_i    (we[0]),
    .req0_addr_i  (addr[0]),
    .req0_din_i   (din[0]),
    .req0_sel_i   (sel[0]),
    .req0_lock_i  (lock[0]),
    .req0_gnt_o   (gnt0),
    .req0_rvalid_o(rv0),
    .req0_dout_o  (dout0),
    .req1_ce_i    (ce[1]),
    .req1_we_i    (we[1]),
    .req1_addr_i  (addr[1]),
    .req1_din_i   (din[1]),
    .req1_sel_i   (sel[1]),
    .req1_lock_i  (lock[1]),
    .req1_gnt_o   (gnt1),
    .req1_rvalid_o(rv1),
    .req1_dout_o  (dout1),
    .sram_ce      (sram_ce),
    .sram_we      (sram_we),
    .sram_waddr   (sram_waddr),
    .sram_din     (sram_din),
    .sram_sel     (sram_sel),
    .sram_dout    (sram_dout)
  );

  function automatic logic [XLEN-1:0] init_word(input int a);
    return XLEN'(32'hC0DE_1234 ^ (32'(a) * 32'h0101_0001));
  endfunction

  // Synchronous SRAM: byte-enabled write, read data one cycle later
  logic [XLEN-1:0] mem [DEPTH];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < int'(DEPTH); a++) mem[a] <= init_word(a);
      mem_ready <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < int'(SW); b++)
          if (sram_sel[b]) mem[sram_waddr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= mem[sram_waddr];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int              owner;
    logic [XLEN-1:0] data;
  } rd_t;

  logic [XLEN-1:0] ref_mem [DEPTH];
  rd_t             rd_q [$];
  int              ref_last;
  bit              ref_lock_v;
  int              ref_lock_owner;
  bit              exp_g  [2];
  bit              exp_rv [2];
  logic [XLEN-1:0] exp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected grant/rvalid for the current inputs and model state
  task automatic model_eval();
    bit elig [2];
    for (int n = 0; n < 2; n++) begin
      elig[n]   = ce[n];
      exp_g[n]  = 1'b0;
      exp_rv[n] = 1'b0;
    end
`ifdef SOC_SRAM_ARB_LOCK_EN
    if (ref_lock_v && lock[ref_lock_owner]) elig[1 - ref_lock_owner] = 1'b0;
`endif
    if (!rst) begin
      if (elig[0] && elig[1]) exp_g[1 - ref_last] = 1'b1;
      else for (int n = 0; n < 2; n++) exp_g[n] = elig[n];
    end
    exp_rdata = '0;
    if (!rst && rd_q.size() > 0) begin
      exp_rv[rd_q[0].owner] = 1'b1;
      exp_rdata = rd_q[0].data;
    end
  endtask

  // Advance the model by one clock using the inputs of the cycle just checked
  task automatic model_update();
    bit granted;
    granted = 1'b0;
    if (rd_q.size() > 0) void'(rd_q.pop_front());
    if (rst) begin
      ref_last   = 1;
      ref_lock_v = 1'b0;
      rd_q.delete();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (exp_g[n]) begin
          granted  = 1'b1;
          ref_last = n;
          if (we[n]) begin
            for (int b = 0; b < int'(SW); b++)
              if (sel[n][b]) ref_mem[addr[n]][b*8 +: 8] = din[n][b*8 +: 8];
          end else begin
            rd_q.push_back('{owner: n, data: ref_mem[addr[n]]});
          end
          ref_lock_v     = lock[n];
          ref_lock_owner = n;
        end
      end
      if (!granted && !(ref_lock_v && lock[ref_lock_owner])) ref_lock_v = 1'b0;
    end
  endtask

  // Check DUT against model at mid-cycle
  task automatic settle();
    logic               e_we;
    logic [WORD_AW-1:0] e_wa;
    logic [XLEN-1:0]    e_din;
    logic [SW-1:0]      e_sel;
    #4;
    model_eval();
    e_we = 1'b0; e_wa = '0; e_din = '0; e_sel = '0;
    for (int n = 0; n < 2; n++)
      if (exp_g[n]) begin
        e_we = we[n]; e_wa = addr[n]; e_din = din[n]; e_sel = sel[n];
      end
    chk("gnt0",       64'(gnt0),       64'(exp_g[0]));
    chk("gnt1",       64'(gnt1),       64'(exp_g[1]));
    chk("sram_ce",    64'(sram_ce),    64'(exp_g[0] | exp_g[1]));
    chk("sram_we",    64'(sram_we),    64'(e_we));
    chk("sram_waddr", 64'(sram_waddr), 64'(e_wa));
    chk("sram_din",   64'(sram_din),   64'(e_din));
    chk("sram_sel",   64'(sram_sel),   64'(e_sel));
    chk("rvalid0",    64'(rv0),        64'(exp_rv[0]));
    chk("rvalid1",    64'(rv1),        64'(exp_rv[1]));
    if (exp_rv[0]) chk("dout0", 64'(dout0), 64'(exp_rdata));
    if (exp_rv[1]) chk("dout1", 64'(dout1), 64'(exp_rdata));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input int n, input bit c, input bit w, input int a,
                       input logic [XLEN-1:0] d, input logic [SW-1:0] s, input bit l);
    ce[n] = c; we[n] = w; addr[n] = WORD_AW'(a); din[n] = d; sel[n] = s; lock[n] = l;
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, 0, '0, '0, 0);
  endtask

  typedef struct {
    bit rst, ce0, we0, ce1, we1;
    int a0, a1;
    bit g0, g1, rv0, rv1;
  } vec_t;

  function automatic vec_t mk(bit r, bit c0, bit w0, int a0, bit c1, bit w1, int a1,
                              bit g0, bit g1, bit v0, bit v1);
    vec_t v;
    v.rst = r; v.ce0 = c0; v.we0 = w0; v.a0 = a0; v.ce1 = c1; v.we1 = w1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.rv0 = v0; v.rv1 = v1;
    return v;
  endfunction

  initial begin
    vec_t            tbl [11];
    logic [XLEN-1:0] w5;
    bit              hold [2];

    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = init_word(a);
    ref_last = 1; ref_lock_v = 1'b0; ref_lock_owner = 0;
    rst = 1'b1;
    idle_all();

    // Reset state, two-requester read race, then six cycles of contention
    tbl[0]  = mk(1, 0,0,'h000, 0,0,'h000, 0,0,0,0);
    tbl[1]  = mk(0, 1,0,'h010, 1,0,'h020, 1,0,0,0);
    tbl[2]  = mk(0, 0,0,'h000, 1,0,'h020, 0,1,1,0);
    tbl[3]  = mk(0, 0,0,'h000, 0,0,'h000, 0,0,0,1);
    tbl[4]  = mk(0, 1,0,'h030, 1,0,'h031, 1,0,0,0);
    tbl[5]  = mk(0, 1,0,'h032, 1,0,'h033, 0,1,1,0);
    tbl[6]  = mk(0, 1,0,'h034, 1,0,'h035, 1,0,0,1);
    tbl[7]  = mk(0, 1,0,'h036, 1,0,'h037, 0,1,1,0);
    tbl[8]  = mk(0, 1,0,'h038, 1,0,'h039, 1,0,0,1);
    tbl[9]  = mk(0, 1,0,'h03A, 1,0,'h03B, 0,1,1,0);
    tbl[10] = mk(0, 0,0,'h000, 0,0,'h000, 0,0,0,1);

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      drive(0, tbl[i].ce0, tbl[i].we0, tbl[i].a0, '0, '1, 0);
      drive(1, tbl[i].ce1, tbl[i].we1, tbl[i].a1, '0, '1, 0);
      settle();
      chk($sformatf("tbl%0d_gnt0", i),   64'(gnt0), 64'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i),   64'(gnt1), 64'(tbl[i].g1));
      chk($sformatf("tbl%0d_rvalid0", i), 64'(rv0), 64'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rvalid1", i), 64'(rv1), 64'(tbl[i].rv1));
      if (i == 1) chk("tbl1_waddr", 64'(sram_waddr), 64'h010);
      if (i == 2) chk("tbl2_dout0", 64'(dout0), 64'(init_word('h010)));
      if (i == 3) chk("tbl3_dout1", 64'(dout1), 64'(init_word('h020)));
      advance();
    end

    // Partial write then read-back on requester 1
    drive(1, 1, 1, 'h005, 32'hDEAD_BEEF, SW'(4'b0011), 0);
    settle();
    chk("wr5_gnt1", 64'(gnt1), 64'h1);
    advance();
    drive(1, 1, 0, 'h005, '0, '1, 0);
    settle();
    chk("wr5_no_rvalid", 64'(rv1), 64'h0);
    advance();
    idle_all();
    settle();
    w5 = init_word('h005);
    chk("rd5_rvalid1", 64'(rv1), 64'h1);
    chk("rd5_data", 64'(dout1), 64'({w5[31:16], 16'hBEEF}));
    advance();

    // Reset lands the cycle after a read is granted
    drive(0, 1, 0, 'h007, '0, '1, 0);
    settle();
    chk("rstrd_gnt0", 64'(gnt0), 64'h1);
    advance();
    idle_all();
    rst = 1'b1;
    settle();
    chk("rstrd_rvalid_in_rst", 64'(rv0), 64'h0);
    advance();
    rst = 1'b0;
    settle();
    chk("rstrd_rvalid_after", 64'(rv0), 64'h0);
    advance();
    drive(0, 1, 0, 'h008, '0, '1, 0);
    drive(1, 1, 0, 'h009, '0, '1, 0);
    settle();
    chk("rst_first_conflict_gnt0", 64'(gnt0), 64'h1);
    advance();
    idle_all();
    settle();
    advance();

    // Requester 0 holds a lock for three cycles while requester 1 waits
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    drive(0, 1, 1, 'h040, 32'h1111_0000, '1, 1);
    drive(1, 1, 1, 'h041, 32'h2222_0000, '1, 0);
    settle();
    chk("lock_c1_gnt0", 64'(gnt0), 64'h1);
    advance();
    drive(0, 0, 0, 0, '0, '0, 1);
    settle();
`ifdef SOC_SRAM_ARB_LOCK_EN
    chk("lock_c2_gnt1", 64'(gnt1), 64'h0);
`else
    chk("lock_c2_gnt1", 64'(gnt1), 64'h1);
`endif
    advance();
    drive(0, 1, 1, 'h042, 32'h1111_0002, '1, 1);
    settle();
    chk("lock_c3_gnt0", 64'(gnt0), 64'h1);
    chk("lock_c3_gnt1", 64'(gnt1), 64'h0);
    advance();
    drive(0, 1, 1, 'h043, 32'h1111_0003, '1, 0);
    settle();
    chk("lock_release_gnt1", 64'(gnt1), 64'h1);
    advance();
    idle_all();
    settle();
    advance();

    // Randomized traffic; a waiting requester keeps its request stable
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          drive(n, ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                int'($urandom_range(0, 15)), XLEN'($urandom), SW'($urandom),
                ($urandom_range(0, 3) == 0));
        end
      end
      settle();
      for (int n = 0; n < 2; n++) hold[n] = ce[n] && !exp_g[n] && !rst;
      advance();
    end
    rst = 1'b0;
    idle_all();
    settle();
    advance();
    settle();
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
